regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the 8x13-bit RegisterFile and the ALU.
//  Accepts 16-bit instructions over a valid/ready handshake and drives the register pointers, ALU opcode,
//  WriteFlag and register-file Reset. WriteFlag is a clean one-cycle pulse with R1 and AluOp stable
//  before, during and after it, because the register file writes on the WriteFlag level.
//  Sits between the instruction source and the RegisterFile/ALU pair.
// PARAMETERS
//  ALU_LATENCY  1      cycles spent in EXECUTE waiting for ALU_Result to settle; legal range 1..15
//  OP_HALT      4'hF   opcode that stops the sequencer until reset
// PORTS
//  Clock        in   1   system clock, rising edge
//  ResetN       in   1   synchronous, active-low reset
//  Instr        in   16  {Op[15:12], R1[11:9], R2[8:6], R3[5:3], unused[2:0]}
//  InstrValid   in   1   Instr is valid
//  InstrReady   out  1   sequencer accepts Instr this cycle (combinational)
//  ClearReq     in   1   request to clear all registers
//  R1,R2,R3     out  3   register pointers to RegisterFile (registered)
//  AluOp        out  4   opcode to ALU (registered)
//  WriteFlag    out  1   write strobe to RegisterFile
//  RegFileReset out  1   clear strobe to the RegisterFile Reset input
//  Busy         out  1   high in every state except IDLE and HALTED
//  Halted       out  1   high in HALTED
//  InstrCount   out  8   retired-instruction count, wraps 255->0
// BEHAVIOUR
//  States: CLEAR, IDLE, DECODE, EXECUTE, WRITEBACK, HALTED.
//  - Reset (ResetN=0 at an edge) enters CLEAR from any state, including mid-instruction.
//  - Reset values: R1/R2/R3=0, AluOp=0, WriteFlag=0, InstrCount=0, Halted=0, InstrReady=0.
//  - Because the reset state is CLEAR: RegFileReset=1 and Busy=1 out of reset.
//  - An in-flight instruction is discarded on reset; no write occurs.
//  CLEAR: RegFileReset=1 for exactly one cycle, then IDLE.
//  IDLE: InstrReady = ~ClearReq.
//   ClearReq=1 -> CLEAR; any InstrValid is ignored that cycle (clear wins).
//   InstrValid&InstrReady -> accept: latch R1/R2/R3/AluOp from Instr, then DECODE.
//  DECODE (1 cycle):
//   Op=4'h0 (NOP) -> IDLE, InstrCount+1.
//   Op=OP_HALT -> HALTED, InstrCount+1.
//   Any other Op -> EXECUTE, counter loaded with ALU_LATENCY.
//  EXECUTE: stay ALU_LATENCY cycles, then WRITEBACK.
//  WRITEBACK (1 cycle): WriteFlag=1, InstrCount+1, then IDLE.
//  HALTED: InstrReady=0; ClearReq and InstrValid are ignored; exit only by reset.
//  Outputs are decoded from registered state: WriteFlag = (state==WRITEBACK); RegFileReset = (state==CLEAR).
//  R1/R2/R3/AluOp change only on accept, so they are stable for at least one cycle on each side of WriteFlag.
//  Timing (accept in cycle 0): WriteFlag high in cycle 2+ALU_LATENCY; InstrReady high again in cycle 3+ALU_LATENCY.
//  With ALU_LATENCY=1 this gives WriteFlag in cycle 3 and a throughput of 1 instruction per 4 cycles.
//  WriteFlag and RegFileReset are never high in the same cycle.
//  InstrCount increments at most once per cycle; 8'hFF+1 -> 8'h00.
// TESTING
//  T1 Release reset -> RegFileReset=1 for 1 cycle, then IDLE with InstrReady=1, InstrCount=0.
//  T2 ALU_LATENCY=1, Instr=16'h1298 (Op1,R1=1,R2=2,R3=3), accept in c0 ->
//     R1=1/R2=2/R3=3/AluOp=1 from c1; WriteFlag=1 only in c3; InstrReady=1 in c4; InstrCount=1.
//  T3 Instr=16'h0000 (NOP) -> no WriteFlag; back to IDLE 2 cycles after accept; InstrCount+1.
//  T4 ClearReq=1 and InstrValid=1 in the same IDLE cycle -> InstrReady=0, instruction not accepted;
//     RegFileReset pulses 1 cycle; the same instruction is then accepted the following cycle.
//  T5 Instr=16'hF000 (HALT) -> Halted=1, InstrReady=0; later InstrValid/ClearReq cause no change;
//     ResetN=0 -> CLEAR.
//  T6 ResetN=0 during EXECUTE -> WriteFlag never asserts, next state CLEAR;
//     256 back-to-back NOPs -> InstrCount wraps to 0.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for the 8x13 register file and ALU: accepts instructions over
// valid/ready, drives register pointers and opcode, and strobes WriteFlag and RegFileReset.
module regfile_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [3:0]  OP_HALT     = 4'hF
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic [15:0] Instr,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic        ClearReq,
  output logic [2:0]  R1,
  output logic [2:0]  R2,
  output logic [2:0]  R3,
  output logic [3:0]  AluOp,
  output logic        WriteFlag,
  output logic        RegFileReset,
  output logic        Busy,
  output logic        Halted,
  output logic [7:0]  InstrCount
);

  // state     | meaning
  // CLEAR     | one-cycle clear strobe to the register file
  // IDLE      | waiting for an instruction or a clear request
  // DECODE    | NOP/HALT retire here, others start the ALU timer
  // EXECUTE   | waiting ALU_LATENCY cycles for the ALU result
  // WRITEBACK | one-cycle write strobe, instruction retires
  // HALTED    | parked until reset
  typedef enum logic [2:0] {
    ST_CLEAR     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] LAT    = 4'(ALU_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  r1_q, r1_d;
  logic [2:0]  r2_q, r2_d;
  logic [2:0]  r3_q, r3_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [7:0]  count_q, count_d;
  logic        accept;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^Instr[2:0];

  assign InstrReady = (state_q == ST_IDLE) && !ClearReq;
  assign accept     = InstrValid && InstrReady;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    alu_op_d = alu_op_q;
    count_d  = count_q;
    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE: begin
        if (ClearReq) begin
          state_d = ST_CLEAR;
        end else if (accept) begin
          alu_op_d = Instr[15:12];
          r1_d     = Instr[11:9];
          r2_d     = Instr[8:6];
          r3_d     = Instr[5:3];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (alu_op_q == OP_NOP) begin
          state_d = ST_IDLE;
          count_d = count_q + 8'd1;
        end else if (alu_op_q == OP_HALT) begin
          state_d = ST_HALTED;
          count_d = count_q + 8'd1;
        end else begin
          state_d = ST_EXECUTE;
          cnt_d   = LAT;
        end
      end
      ST_EXECUTE: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_WRITEBACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_IDLE;
        count_d = count_q + 8'd1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_CLEAR;
    endcase
  end

  // Reset lands in CLEAR so the register file is wiped on every reset, mid-instruction included.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= 4'd0;
      r1_q     <= 3'd0;
      r2_q     <= 3'd0;
      r3_q     <= 3'd0;
      alu_op_q <= 4'd0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      alu_op_q <= alu_op_d;
      count_q  <= count_d;
    end
  end

  assign R1           = r1_q;
  assign R2           = r2_q;
  assign R3           = r3_q;
  assign AluOp        = alu_op_q;
  assign InstrCount   = count_q;
  assign WriteFlag    = (state_q == ST_WRITEBACK);
  assign RegFileReset = (state_q == ST_CLEAR);
  assign Halted       = (state_q == ST_HALTED);
  assign Busy         = (state_q != ST_IDLE) && (state_q != ST_HALTED);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: expected writebacks are queued on accept
// and compared by a monitor whenever WriteFlag is seen.
module tb_regfile_sequencer;

  localparam int LAT = 1;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic [15:0] Instr = 16'h0000;
  logic        InstrValid = 1'b0;
  logic        ClearReq = 1'b0;
  logic        InstrReady;
  logic [2:0]  R1, R2, R3;
  logic [3:0]  AluOp;
  logic        WriteFlag, RegFileReset, Busy, Halted;
  logic [7:0]  InstrCount;

  typedef struct {
    int         wr_cyc;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] r3;
    logic [3:0] op;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_count = 8'd0;

  regfile_sequencer #(.ALU_LATENCY(LAT), .OP_HALT(4'hF)) dut (
    .Clock(Clock), .ResetN(ResetN), .Instr(Instr), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .ClearReq(ClearReq), .R1(R1), .R2(R2), .R3(R3),
    .AluOp(AluOp), .WriteFlag(WriteFlag), .RegFileReset(RegFileReset),
    .Busy(Busy), .Halted(Halted), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  // Writeback monitor: every WriteFlag must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (WriteFlag) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: WriteFlag=1 at cycle %0d with no pending instruction", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc != e.wr_cyc || {R1, R2, R3, AluOp} !== {e.r1, e.r2, e.r3, e.op} || RegFileReset !== 1'b0) begin
          errors++;
          $display("FAIL writeback: got cyc=%0d R=%0d/%0d/%0d op=%h rfr=%b, want cyc=%0d R=%0d/%0d/%0d op=%h rfr=0",
                   cyc, R1, R2, R3, AluOp, RegFileReset, e.wr_cyc, e.r1, e.r2, e.r3, e.op);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] ins, output int acc_cyc);
    int n = 0;
    exp_t e;
    Instr = ins;
    InstrValid = 1'b1;
    #1;
    while (!InstrReady && n < 50) begin
      @(negedge Clock); #1;
      n++;
    end
    checks++;
    if (!InstrReady) begin
      errors++;
      $display("FAIL send_timeout: InstrReady=%b, want 1 within 50 cycles", InstrReady);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      exp_count = exp_count + 8'd1;
      if (ins[15:12] != 4'h0 && ins[15:12] != 4'hF) begin
        e.wr_cyc = cyc + 2 + LAT;
        e.r1 = ins[11:9]; e.r2 = ins[8:6]; e.r3 = ins[5:3]; e.op = ins[15:12];
        sb.push_back(e);
      end
    end
    @(negedge Clock);
    InstrValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (Busy) begin
      errors++;
      $display("FAIL idle_timeout: Busy=%b, want 0 within 100 cycles", Busy);
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({RegFileReset, Busy, InstrReady, WriteFlag, Halted} !== 5'b11000 ||
        {R1, R2, R3, AluOp, InstrCount} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values: rfr/busy/rdy/wf/halt=%b%b%b%b%b R=%0d/%0d/%0d op=%h cnt=%0d, want 11000 and zeros",
               RegFileReset, Busy, InstrReady, WriteFlag, Halted, R1, R2, R3, AluOp, InstrCount);
    end
    ResetN = 1'b1;
    @(negedge Clock);
    checks++;
    if ({RegFileReset, InstrReady, Busy} !== 3'b010 || InstrCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: rfr/rdy/busy=%b%b%b cnt=%0d, want 010 cnt=0",
               RegFileReset, InstrReady, Busy, InstrCount);
    end
    exp_count = 8'd0;
  endtask

  task automatic test_alu();
    exp_t e;
    Instr = 16'h1298;
    InstrValid = 1'b1;
    #1;
    checks++;
    if (InstrReady !== 1'b1) begin
      errors++;
      $display("FAIL alu_ready_c0: InstrReady=%b, want 1", InstrReady);
    end
    e.wr_cyc = cyc + 2 + LAT; e.r1 = 3'd1; e.r2 = 3'd2; e.r3 = 3'd3; e.op = 4'h1;
    sb.push_back(e);
    exp_count = exp_count + 8'd1;
    @(negedge Clock);
    InstrValid = 1'b0;
    checks++;
    if ({R1, R2, R3, AluOp} !== {3'd1, 3'd2, 3'd3, 4'h1} || WriteFlag !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL alu_latch_c1: R=%0d/%0d/%0d op=%h wf=%b busy=%b, want 1/2/3 op=1 wf=0 busy=1",
               R1, R2, R3, AluOp, WriteFlag, Busy);
    end
    @(negedge Clock);
    checks++;
    if (WriteFlag !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_write_c2: WriteFlag=%b, want 0", WriteFlag);
    end
    @(negedge Clock);
    checks++;
    if (WriteFlag !== 1'b1 || InstrReady !== 1'b0) begin
      errors++;
      $display("FAIL alu_write_c3: WriteFlag=%b InstrReady=%b, want 1 0", WriteFlag, InstrReady);
    end
    @(negedge Clock);
    checks++;
    if (InstrReady !== 1'b1 || WriteFlag !== 1'b0 || InstrCount !== 8'd1 || R1 !== 3'd1 || AluOp !== 4'h1) begin
      errors++;
      $display("FAIL alu_done_c4: rdy=%b wf=%b cnt=%0d R1=%0d op=%h, want 1 0 1 1 1",
               InstrReady, WriteFlag, InstrCount, R1, AluOp);
    end
  endtask

  task automatic test_nop();
    int a;
    send(16'h0000, a);
    @(negedge Clock);
    checks++;
    if (InstrReady !== 1'b1 || Busy !== 1'b0 || InstrCount !== exp_count) begin
      errors++;
      $display("FAIL nop_return: rdy=%b busy=%b cnt=%0d, want 1 0 %0d", InstrReady, Busy, InstrCount, exp_count);
    end
  endtask

  task automatic test_clear_wins();
    exp_t e;
    ClearReq = 1'b1;
    Instr = 16'h2A50;
    InstrValid = 1'b1;
    #1;
    checks++;
    if (InstrReady !== 1'b0) begin
      errors++;
      $display("FAIL clear_blocks_ready: InstrReady=%b, want 0", InstrReady);
    end
    @(negedge Clock);
    ClearReq = 1'b0;
    #1;
    checks++;
    if (RegFileReset !== 1'b1 || InstrReady !== 1'b0 || AluOp !== 4'h0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_pulse: rfr=%b rdy=%b op=%h busy=%b, want 1 0 0 1", RegFileReset, InstrReady, AluOp, Busy);
    end
    @(negedge Clock); #1;
    checks++;
    if (RegFileReset !== 1'b0 || InstrReady !== 1'b1) begin
      errors++;
      $display("FAIL clear_one_cycle: rfr=%b rdy=%b, want 0 1", RegFileReset, InstrReady);
    end
    e.wr_cyc = cyc + 2 + LAT; e.r1 = 3'd5; e.r2 = 3'd1; e.r3 = 3'd2; e.op = 4'h2;
    sb.push_back(e);
    exp_count = exp_count + 8'd1;
    @(negedge Clock);
    InstrValid = 1'b0;
    checks++;
    if ({R1, R2, R3, AluOp} !== {3'd5, 3'd1, 3'd2, 4'h2}) begin
      errors++;
      $display("FAIL clear_then_accept: R=%0d/%0d/%0d op=%h, want 5/1/2 op=2", R1, R2, R3, AluOp);
    end
    wait_idle();
    checks++;
    if (InstrCount !== exp_count) begin
      errors++;
      $display("FAIL clear_count: InstrCount=%0d, want %0d", InstrCount, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int a;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(1, 14));
      send({op, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)}, a);
      if (prev >= 0) begin
        checks++;
        if (a - prev != 3 + LAT) begin
          errors++;
          $display("FAIL throughput: accept spacing=%0d, want %0d", a - prev, 3 + LAT);
        end
      end
      prev = a;
    end
    wait_idle();
    checks++;
    if (InstrCount !== exp_count) begin
      errors++;
      $display("FAIL b2b_count: InstrCount=%0d, want %0d", InstrCount, exp_count);
    end
  endtask

  task automatic test_halt();
    int a;
    send(16'hF000, a);
    @(negedge Clock);
    checks++;
    if ({Halted, InstrReady, Busy} !== 3'b100 || InstrCount !== exp_count) begin
      errors++;
      $display("FAIL halt_enter: halt/rdy/busy=%b%b%b cnt=%0d, want 100 cnt=%0d",
               Halted, InstrReady, Busy, InstrCount, exp_count);
    end
    Instr = 16'h1298;
    InstrValid = 1'b1;
    ClearReq = 1'b1;
    repeat (3) begin
      @(negedge Clock); #1;
      checks++;
      if ({Halted, RegFileReset, InstrReady} !== 3'b100 || InstrCount !== exp_count) begin
        errors++;
        $display("FAIL halt_sticky: halt/rfr/rdy=%b%b%b cnt=%0d, want 100 cnt=%0d",
                 Halted, RegFileReset, InstrReady, InstrCount, exp_count);
      end
    end
    InstrValid = 1'b0;
    ClearReq = 1'b0;
    ResetN = 1'b0;
    @(negedge Clock);
    checks++;
    if ({RegFileReset, Halted, Busy} !== 3'b101 || InstrCount !== 8'd0) begin
      errors++;
      $display("FAIL halt_reset: rfr/halt/busy=%b%b%b cnt=%0d, want 101 cnt=0", RegFileReset, Halted, Busy, InstrCount);
    end
    ResetN = 1'b1;
    exp_count = 8'd0;
    @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    int a;
    send(16'h36C8, a);
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b1 || WriteFlag !== 1'b0) begin
      errors++;
      $display("FAIL mid_execute: busy=%b wf=%b, want 1 0", Busy, WriteFlag);
    end
    ResetN = 1'b0;
    sb.delete();
    exp_count = 8'd0;
    @(negedge Clock);
    checks++;
    if (WriteFlag !== 1'b0 || RegFileReset !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: wf=%b rfr=%b, want 0 1", WriteFlag, RegFileReset);
    end
    ResetN = 1'b1;
    repeat (3) @(negedge Clock);
    checks++;
    if (InstrCount !== 8'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: cnt=%0d busy=%b, want 0 0", InstrCount, Busy);
    end
  endtask

  task automatic test_wrap();
    int a;
    for (int i = 0; i < 255; i++) send(16'h0000, a);
    wait_idle();
    checks++;
    if (InstrCount !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_255: InstrCount=%0d, want 255", InstrCount);
    end
    send(16'h0000, a);
    wait_idle();
    checks++;
    if (InstrCount !== 8'h00 || InstrCount !== exp_count) begin
      errors++;
      $display("FAIL wrap_0: InstrCount=%0d, want 0", InstrCount);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_nop();
    test_clear_wins();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: %0d expected writebacks never seen, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
